// File: rtl/lsu.sv
// Load/store unit: byte/half/word requests to a word-indexed dmem, with read-modify-write for sub-word stores.
// Optional feature: define LSU_MISALIGN_TRAP_EN to flag misaligned accesses instead of masking the low address bits.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        MERGE = 2'b10
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [15:0] wdata_q;
    logic        accept;
    logic        misaligned;
    logic        mem_write_raw;

    // Pick the addressed lane out of a dmem word and extend it to 32 bits.
    function automatic logic [31:0] extract(input logic [31:0] word,
                                            input logic [1:0]  size,
                                            input logic        uns,
                                            input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        b = 8'h00;
        h = 16'h0000;
        case (size)
            2'b00: begin
                case (lane)
                    2'b00:   b = word[7:0];
                    2'b01:   b = word[15:8];
                    2'b10:   b = word[23:16];
                    default: b = word[31:24];
                endcase
                result = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            end
            2'b01: begin
                h = lane[1] ? word[31:16] : word[15:0];
                result = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            end
            default: result = word;
        endcase
        return result;
    endfunction

    // Overlay the store data onto the old word for a sub-word store.
    function automatic logic [31:0] merge(input logic [31:0] word,
                                          input logic [15:0] data,
                                          input logic        is_half,
                                          input logic [1:0]  lane);
        logic [31:0] result;
        result = word;
        if (is_half) begin
            if (lane[1]) result[31:16] = data;
            else         result[15:0]  = data;
        end else begin
            case (lane)
                2'b00:   result[7:0]   = data[7:0];
                2'b01:   result[15:8]  = data[7:0];
                2'b10:   result[23:16] = data[7:0];
                default: result[31:24] = data[7:0];
            endcase
        end
        return result;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = (req_size[1] && (req_addr[1:0] != 2'b00)) ||
                        ((req_size == 2'b01) && req_addr[0]);
`else
    assign misaligned = 1'b0;
`endif

    assign req_ready = rst_n && (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_next    = state;
        mem_write_raw = 1'b0;
        mem_wdata     = req_wdata;
        mem_addr      = {2'b00, req_addr[31:2]};
        case (state)
            IDLE: begin
                if (accept && !misaligned) begin
                    if (req_we && req_size[1]) mem_write_raw = 1'b1;
                    else if (req_we)           state_next    = MERGE;
                    else                       state_next    = LOAD;
                end
            end
            LOAD: begin
                mem_addr   = {2'b00, addr_q[31:2]};
                state_next = IDLE;
            end
            MERGE: begin
                mem_addr      = {2'b00, addr_q[31:2]};
                mem_write_raw = 1'b1;
                mem_wdata     = merge(mem_rdata, wdata_q, size_q[0], addr_q[1:0]);
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A write must never reach dmem while reset is asserted, even mid-RMW.
    assign mem_write = mem_write_raw && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= 32'h0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            wdata_q    <= 16'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            state      <= state_next;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            if (accept) begin
                addr_q     <= req_addr;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                wdata_q    <= req_wdata[15:0];
                if (misaligned || (req_we && req_size[1])) resp_valid <= 1'b1;
            end
            if (state == LOAD) begin
                resp_valid <= 1'b1;
                resp_rdata <= extract(mem_rdata, size_q, unsigned_q, addr_q[1:0]);
            end
            if (state == MERGE) resp_valid <= 1'b1;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) resp_err <= 1'b0;
        else        resp_err <= accept && misaligned;
    end
`else
    assign resp_err = 1'b0;
`endif

endmodule
